// File: rtl/brd_wb2ps_wc_pkg.sv
// Shared definitions for the write-back cache lookup controller.
// Holds the FSM state encoding, the cache geometry constants and the
// packed register bundle that carries every registered controller output.
package brd_wb2ps_wc_pkg;

    localparam int WAY_NUM  = 4;
    localparam int LINE_NUM = 16;
    localparam int TAG_W    = 13;
    localparam int AGE_W    = 2;
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_CMP    = 3'd3,
        ST_MISS   = 3'd4,
        ST_FILL   = 3'd5
    } state_e;

    // Every output of the controller plus the latched request lives here so
    // that one reset assignment clears them all together.
    typedef struct packed {
        logic         req_ready;
        logic         we;
        logic [22:2]  adr;
        logic [31:0]  wdata;
        logic [3:0]   strb;
        logic         read_tag;
        logic [3:0]   read_lineno;
        logic [3:0]   read_adr_lsb;
        logic         rsp_valid;
        logic [31:0]  rsp_rdata;
        logic         rewrite_lru;
        logic [7:0]   w_lru;
        logic [3:0]   rewrite_tag;
        logic [22:10] w_tagadr;
        logic         w_valid;
        logic         w_dirty;
        logic [3:0]   w_dc;
        logic         taginit_en;
        logic [3:0]   taginit_lineno;
        logic         miss_req;
        logic [3:0]   miss_way;
        logic         miss_victim_dirty;
        logic [22:10] miss_victim_tagadr;
    } ctl_regs_t;

endpackage

// File: rtl/brd_wb2ps_wc_lru_upd.sv
// LRU age update and victim selection for one 4-way cache line.
// Ports:
//   age_i    : current 2-bit ages, way0 in the LSBs (0 = most recent)
//   hit_i    : one-hot hit way (all zero on a miss)
//   valid_i  : per-way valid bits
//   age_o    : ages after promoting the hit way to 0
//   victim_o : one-hot replacement way
// Purely combinational.
module brd_wb2ps_wc_lru_upd
    import brd_wb2ps_wc_pkg::*;
(
    input  logic [WAY_NUM*AGE_W-1:0] age_i,
    input  logic [WAY_NUM-1:0]       hit_i,
    input  logic [WAY_NUM-1:0]       valid_i,
    output logic [WAY_NUM*AGE_W-1:0] age_o,
    output logic [WAY_NUM-1:0]       victim_o
);

    logic [AGE_W-1:0]   hit_age;
    logic [WAY_NUM-1:0] oldest;
    logic [WAY_NUM-1:0] invalid;

    always_comb begin
        hit_age = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (hit_i[w]) begin
                hit_age = hit_age | age_i[w*AGE_W +: AGE_W];
            end
        end
    end

    // Ways younger than the hit way age by one; older ways keep their age,
    // which keeps the four ages a permutation of 0..3. With no hit, hit_age
    // is 0 and nothing moves.
    generate
        for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way
            logic [AGE_W-1:0] age_w;
            assign age_w = age_i[gi*AGE_W +: AGE_W];
            assign age_o[gi*AGE_W +: AGE_W] = hit_i[gi]        ? '0 :
                                              (age_w < hit_age) ? age_w + AGE_W'(1) :
                                                                  age_w;
            assign oldest[gi] = (age_w == {AGE_W{1'b1}});
        end
    endgenerate

    // Lowest-numbered invalid way wins over the oldest valid way.
    assign invalid  = ~valid_i;
    assign victim_o = (|invalid) ? (invalid & (~invalid + WAY_NUM'(1))) : oldest;

endmodule

// File: rtl/brd_wb2ps_wc_lookup_ctl.sv
// Lookup controller of a 4-way write-back cache.
// Accepts one CPU request at a time, reads tag and data RAM, compares the
// four tags, answers read hits, writes on write hits, updates LRU ages, and
// on a miss requests a refill, then rewrites the victim tag and replays.
// Ports:
//   cpuclk / WSHRST_N        : clock, synchronous active-low reset
//   req_*                    : CPU request handshake and fields
//   rsp_valid / rsp_rdata    : read response pulse
//   READ_TAG / READ_DATA_BUS : RAM read strobes, index on read_lineno/read_adr_lsb
//   tag_* / rf_cache_rdata_i : RAM readout, valid in the cycle after the strobe
//   rewrite_lru / w_lru      : LRU write
//   rewrite_tag / w_*        : tag write;  w_dc / r_w_* : data write on hit
//   taginit_*                : tag initialisation sweep after reset
//   miss_*                   : refill request and victim information
// Every output is a register.
module brd_wb2ps_wc_lookup_ctl #(
    parameter int LINE_NUM = 16
) (
    input  logic          cpuclk,
    input  logic          WSHRST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [22:2]   req_adr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_strb,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          READ_TAG,
    output logic          READ_DATA_BUS,
    output logic [9:6]    read_lineno,
    output logic [5:2]    read_adr_lsb,
    input  logic [51:0]   tag_addr_i,
    input  logic [3:0]    tag_valid_i,
    input  logic [3:0]    tag_dirty_i,
    input  logic [7:0]    tag_lru_i,
    input  logic [127:0]  rf_cache_rdata_i,
    output logic          rewrite_lru,
    output logic [7:0]    w_lru,
    output logic [3:0]    rewrite_tag,
    output logic [22:10]  w_tagadr,
    output logic          w_valid,
    output logic          w_dirty,
    output logic [3:0]    w_dc,
    output logic [22:2]   r_w_adrs,
    output logic [31:0]   r_w_wdata,
    output logic [3:0]    r_w_strb,
    output logic          taginit_en,
    output logic [9:6]    taginit_lineno,
    output logic          miss_req,
    output logic [3:0]    miss_way,
    output logic          miss_victim_dirty,
    output logic [22:10]  miss_victim_tagadr,
    input  logic          miss_done
);
    import brd_wb2ps_wc_pkg::*;

    // One extra bit so the sweep can count to LINE_NUM and stop there.
    localparam int CNT_W = $clog2(LINE_NUM) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    ctl_regs_t         regs_q, regs_d;

    logic [WAY_NUM-1:0]       hit;
    logic [WAY_NUM-1:0]       victim;
    logic [WAY_NUM*AGE_W-1:0] lru_new;
    logic [DATA_W-1:0]        hit_data;
    logic                     victim_dirty;
    logic [TAG_W-1:0]         victim_tag;

    generate
        for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_cmp
            assign hit[gi] = tag_valid_i[gi] &
                             (tag_addr_i[gi*TAG_W +: TAG_W] == regs_q.adr[22:10]);
        end
    endgenerate

    always_comb begin
        hit_data     = '0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (hit[w]) begin
                hit_data = hit_data | rf_cache_rdata_i[w*DATA_W +: DATA_W];
            end
            if (victim[w]) begin
                victim_dirty = victim_dirty | tag_dirty_i[w];
                victim_tag   = victim_tag | tag_addr_i[w*TAG_W +: TAG_W];
            end
        end
    end

    brd_wb2ps_wc_lru_upd u_lru (
        .age_i    (tag_lru_i),
        .hit_i    (hit),
        .valid_i  (tag_valid_i),
        .age_o    (lru_new),
        .victim_o (victim)
    );

    always_ff @(posedge cpuclk) begin
        if (!WSHRST_N) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            regs_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        regs_d     = regs_q;
        // Strobes are one-cycle pulses; data fields hold their last value.
        regs_d.read_tag    = 1'b0;
        regs_d.rsp_valid   = 1'b0;
        regs_d.rewrite_lru = 1'b0;
        regs_d.rewrite_tag = '0;
        regs_d.w_dc        = '0;
        regs_d.taginit_en  = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Leave one cycle after the last sweep pulse so req_ready
                // never overlaps taginit_en.
                if (init_cnt_q == CNT_W'(LINE_NUM)) begin
                    state_d = ST_IDLE;
                end else begin
                    regs_d.taginit_en     = 1'b1;
                    regs_d.taginit_lineno = 4'(init_cnt_q);
                    init_cnt_d            = init_cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid && regs_q.req_ready) begin
                    regs_d.we           = req_we;
                    regs_d.adr          = req_adr;
                    regs_d.wdata        = req_wdata;
                    regs_d.strb         = req_strb;
                    regs_d.read_tag     = 1'b1;
                    regs_d.read_lineno  = req_adr[9:6];
                    regs_d.read_adr_lsb = req_adr[5:2];
                    state_d             = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (|hit) begin
                    regs_d.rewrite_lru = 1'b1;
                    regs_d.w_lru       = lru_new;
                    if (regs_q.we) begin
                        regs_d.w_dc        = hit;
                        regs_d.rewrite_tag = hit;
                        regs_d.w_tagadr    = regs_q.adr[22:10];
                        regs_d.w_valid     = 1'b1;
                        regs_d.w_dirty     = 1'b1;
                    end else begin
                        regs_d.rsp_valid = 1'b1;
                        regs_d.rsp_rdata = hit_data;
                    end
                    state_d = ST_IDLE;
                end else begin
                    regs_d.miss_req           = 1'b1;
                    regs_d.miss_way           = victim;
                    regs_d.miss_victim_dirty  = victim_dirty;
                    regs_d.miss_victim_tagadr = victim_tag;
                    state_d                   = ST_MISS;
                end
            end
            ST_MISS: begin
                if (miss_done) begin
                    regs_d.miss_req    = 1'b0;
                    regs_d.rewrite_tag = regs_q.miss_way;
                    regs_d.w_tagadr    = regs_q.adr[22:10];
                    regs_d.w_valid     = 1'b1;
                    regs_d.w_dirty     = 1'b0;
                    state_d            = ST_FILL;
                end
            end
            ST_FILL: begin
                // Replay the lookup; the line index is still held.
                regs_d.read_tag = 1'b1;
                state_d         = ST_LOOKUP;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        regs_d.req_ready = (state_d == ST_IDLE);
    end

    assign req_ready          = regs_q.req_ready;
    assign rsp_valid          = regs_q.rsp_valid;
    assign rsp_rdata          = regs_q.rsp_rdata;
    assign READ_TAG           = regs_q.read_tag;
    assign READ_DATA_BUS      = regs_q.read_tag;
    assign read_lineno        = regs_q.read_lineno;
    assign read_adr_lsb       = regs_q.read_adr_lsb;
    assign rewrite_lru        = regs_q.rewrite_lru;
    assign w_lru              = regs_q.w_lru;
    assign rewrite_tag        = regs_q.rewrite_tag;
    assign w_tagadr           = regs_q.w_tagadr;
    assign w_valid            = regs_q.w_valid;
    assign w_dirty            = regs_q.w_dirty;
    assign w_dc               = regs_q.w_dc;
    assign r_w_adrs           = regs_q.adr;
    assign r_w_wdata          = regs_q.wdata;
    assign r_w_strb           = regs_q.strb;
    assign taginit_en         = regs_q.taginit_en;
    assign taginit_lineno     = regs_q.taginit_lineno;
    assign miss_req           = regs_q.miss_req;
    assign miss_way           = regs_q.miss_way;
    assign miss_victim_dirty  = regs_q.miss_victim_dirty;
    assign miss_victim_tagadr = regs_q.miss_victim_tagadr;

endmodule

// File: tb/tb_brd_wb2ps_wc_lookup_ctl.sv
// Directed bench for brd_wb2ps_wc_lookup_ctl with a behavioural cache RAM.
module tb_brd_wb2ps_wc_lookup_ctl;

    logic          cpuclk;
    logic          WSHRST_N;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [22:2]   req_adr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_strb;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          READ_TAG;
    logic          READ_DATA_BUS;
    logic [9:6]    read_lineno;
    logic [5:2]    read_adr_lsb;
    logic [51:0]   tag_addr_i = '0;
    logic [3:0]    tag_valid_i = '0;
    logic [3:0]    tag_dirty_i = '0;
    logic [7:0]    tag_lru_i = '0;
    logic [127:0]  rf_cache_rdata_i = '0;
    logic          rewrite_lru;
    logic [7:0]    w_lru;
    logic [3:0]    rewrite_tag;
    logic [22:10]  w_tagadr;
    logic          w_valid;
    logic          w_dirty;
    logic [3:0]    w_dc;
    logic [22:2]   r_w_adrs;
    logic [31:0]   r_w_wdata;
    logic [3:0]    r_w_strb;
    logic          taginit_en;
    logic [9:6]    taginit_lineno;
    logic          miss_req;
    logic [3:0]    miss_way;
    logic          miss_victim_dirty;
    logic [22:10]  miss_victim_tagadr;
    logic          miss_done;

    int n_vec = 0;
    int n_err = 0;

    brd_wb2ps_wc_lookup_ctl #(.LINE_NUM(16)) dut (
        .cpuclk             (cpuclk),
        .WSHRST_N           (WSHRST_N),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_adr            (req_adr),
        .req_wdata          (req_wdata),
        .req_strb           (req_strb),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .READ_TAG           (READ_TAG),
        .READ_DATA_BUS      (READ_DATA_BUS),
        .read_lineno        (read_lineno),
        .read_adr_lsb       (read_adr_lsb),
        .tag_addr_i         (tag_addr_i),
        .tag_valid_i        (tag_valid_i),
        .tag_dirty_i        (tag_dirty_i),
        .tag_lru_i          (tag_lru_i),
        .rf_cache_rdata_i   (rf_cache_rdata_i),
        .rewrite_lru        (rewrite_lru),
        .w_lru              (w_lru),
        .rewrite_tag        (rewrite_tag),
        .w_tagadr           (w_tagadr),
        .w_valid            (w_valid),
        .w_dirty            (w_dirty),
        .w_dc               (w_dc),
        .r_w_adrs           (r_w_adrs),
        .r_w_wdata          (r_w_wdata),
        .r_w_strb           (r_w_strb),
        .taginit_en         (taginit_en),
        .taginit_lineno     (taginit_lineno),
        .miss_req           (miss_req),
        .miss_way           (miss_way),
        .miss_victim_dirty  (miss_victim_dirty),
        .miss_victim_tagadr (miss_victim_tagadr),
        .miss_done          (miss_done)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    // ---------------- cache RAM model ----------------
    logic [51:0]  m_tag   [16];
    logic [3:0]   m_val   [16];
    logic [3:0]   m_dirty [16];
    logic [7:0]   m_lru   [16];
    logic [127:0] m_data  [256];   // index {line, word}

    // Way w of entry i holds ((w+1) << 28) + i, e.g. line1 word0 way0 = 0x10000010.
    initial begin
        for (int i = 0; i < 256; i++) begin
            for (int w = 0; w < 4; w++) begin
                m_data[i][w*32 +: 32] = ((32'(w) + 32'd1) << 28) | 32'(i);
            end
        end
    end

    always @(posedge cpuclk) begin
        if (READ_TAG) begin
            tag_addr_i       <= m_tag[read_lineno];
            tag_valid_i      <= m_val[read_lineno];
            tag_dirty_i      <= m_dirty[read_lineno];
            tag_lru_i        <= m_lru[read_lineno];
            rf_cache_rdata_i <= m_data[{read_lineno, read_adr_lsb}];
        end
        if (taginit_en) begin
            m_tag[taginit_lineno]   <= '0;
            m_val[taginit_lineno]   <= '0;
            m_dirty[taginit_lineno] <= '0;
            m_lru[taginit_lineno]   <= 8'h1B;   // ages way0..3 = 3,2,1,0
        end
        for (int w = 0; w < 4; w++) begin
            if (rewrite_tag[w]) begin
                m_tag[read_lineno][w*13 +: 13] <= w_tagadr;
                m_val[read_lineno][w]          <= w_valid;
                m_dirty[read_lineno][w]        <= w_dirty;
            end
            for (int b = 0; b < 4; b++) begin
                if (w_dc[w] && r_w_strb[b]) begin
                    m_data[r_w_adrs[9:2]][w*32 + b*8 +: 8] <= r_w_wdata[b*8 +: 8];
                end
            end
        end
        if (rewrite_lru) begin
            m_lru[read_lineno] <= w_lru;
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(negedge cpuclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_init();
        for (int i = 0; i < 16; i++) begin
            cyc();
            miss_done = 1'b0;
            chk("init_en", taginit_en, 1);
            chk("init_lineno", taginit_lineno, i);
            chk("init_ready", req_ready, 0);
            chk("init_wtag", rewrite_tag, 0);
            chk("init_wdc", w_dc, 0);
            chk("init_wlru", rewrite_lru, 0);
            chk("init_missreq", miss_req, 0);
        end
        cyc();
        chk("init_done_ready", req_ready, 1);
        chk("init_done_en", taginit_en, 0);
    endtask

    // Drives a request, waits for acceptance and steps through LOOKUP and CMP.
    // Returns at the cycle that shows the CMP outcome.
    task automatic issue(input logic we, input logic [22:0] badr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [3:0] exp_line,
                         input logic [3:0] exp_word);
        int waited;
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = badr[22:2];
        req_wdata = wd;
        req_strb  = st;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 32) begin
            cyc();
            waited++;
        end
        chk("accept_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        chk("lk_readtag", READ_TAG, 1);
        chk("lk_readdata", READ_DATA_BUS, 1);
        chk("lk_lineno", read_lineno, exp_line);
        chk("lk_lsb", read_adr_lsb, exp_word);
        chk("lk_ready", req_ready, 0);
        cyc();
        chk("cmp_readtag", READ_TAG, 0);
        chk("cmp_lineno", read_lineno, exp_line);
        cyc();
    endtask

    task automatic check_miss(input logic [3:0] exp_way, input logic exp_dirty,
                              input logic [12:0] exp_vtag);
        chk("miss_req", miss_req, 1);
        chk("miss_way", miss_way, exp_way);
        chk("miss_vdirty", miss_victim_dirty, exp_dirty);
        chk("miss_vtag", miss_victim_tagadr, exp_vtag);
        chk("miss_rsp", rsp_valid, 0);
        chk("miss_wlru", rewrite_lru, 0);
        repeat (3) cyc();
        chk("miss_hold", miss_req, 1);
    endtask

    // Completes the refill, checks the FILL tag write and the replay lookup.
    task automatic fill_replay(input logic [3:0] exp_way, input logic [12:0] exp_tag,
                               input logic [3:0] exp_line);
        miss_done = 1'b1;
        cyc();
        miss_done = 1'b0;
        chk("fill_wtag", rewrite_tag, exp_way);
        chk("fill_tagadr", w_tagadr, exp_tag);
        chk("fill_valid", w_valid, 1);
        chk("fill_dirty", w_dirty, 0);
        chk("fill_missreq", miss_req, 0);
        cyc();
        chk("replay_readtag", READ_TAG, 1);
        chk("replay_wtag", rewrite_tag, 0);
        chk("replay_lineno", read_lineno, exp_line);
        cyc();
        cyc();
    endtask

    task automatic check_read_hit(input logic [31:0] exp_data, input logic [7:0] exp_lru);
        chk("hit_rsp", rsp_valid, 1);
        chk("hit_rdata", rsp_rdata, exp_data);
        chk("hit_wlru", rewrite_lru, 1);
        chk("hit_lru", w_lru, exp_lru);
        chk("hit_missreq", miss_req, 0);
        chk("hit_wdc", w_dc, 0);
        chk("hit_ready", req_ready, 1);
        cyc();
        chk("hit_rsp_pulse", rsp_valid, 0);
        chk("hit_wlru_pulse", rewrite_lru, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        WSHRST_N  = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_wdata = '0;
        req_strb  = '0;
        miss_done = 1'b0;
        repeat (3) cyc();
        chk("rst_ready", req_ready, 0);
        chk("rst_taginit", taginit_en, 0);
        chk("rst_missreq", miss_req, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_readtag", READ_TAG, 0);
        chk("rst_wlru", w_lru, 0);
        chk("rst_rdata", rsp_rdata, 0);
        WSHRST_N = 1'b1;
        run_init();

        // Read miss at 0x40: way0 invalid victim, refill, replay hit.
        issue(1'b0, 23'h000040, 32'h0, 4'h0, 4'd1, 4'd0);
        check_miss(4'b0001, 1'b0, 13'h000);
        fill_replay(4'b0001, 13'h000, 4'd1);
        check_read_hit(32'h1000_0010, 8'h6C);

        // Write hit at 0x40 on the lower two bytes.
        issue(1'b1, 23'h000040, 32'hA5A5_5A5A, 4'b0011, 4'd1, 4'd0);
        chk("wr_wdc", w_dc, 4'b0001);
        chk("wr_wtag", rewrite_tag, 4'b0001);
        chk("wr_tagadr", w_tagadr, 13'h000);
        chk("wr_valid", w_valid, 1);
        chk("wr_dirty", w_dirty, 1);
        chk("wr_adrs", r_w_adrs, 21'h000010);
        chk("wr_wdata", r_w_wdata, 32'hA5A5_5A5A);
        chk("wr_strb", r_w_strb, 4'b0011);
        chk("wr_wlru", rewrite_lru, 1);
        chk("wr_lru", w_lru, 8'h6C);
        chk("wr_missreq", miss_req, 0);
        chk("wr_rsp", rsp_valid, 0);
        cyc();
        chk("wr_wdc_pulse", w_dc, 0);
        chk("wr_wtag_pulse", rewrite_tag, 0);
        chk("wr_missreq2", miss_req, 0);

        // Read back the merged word.
        issue(1'b0, 23'h000040, 32'h0, 4'h0, 4'd1, 4'd0);
        check_read_hit(32'h1000_5A5A, 8'h6C);

        // Fill ways 1..3 of line 1 with tags 1..3.
        issue(1'b0, 23'h000440, 32'h0, 4'h0, 4'd1, 4'd0);
        check_miss(4'b0010, 1'b0, 13'h000);
        fill_replay(4'b0010, 13'h001, 4'd1);
        check_read_hit(32'h2000_0010, 8'hB1);

        issue(1'b0, 23'h000840, 32'h0, 4'h0, 4'd1, 4'd0);
        check_miss(4'b0100, 1'b0, 13'h000);
        fill_replay(4'b0100, 13'h002, 4'd1);
        check_read_hit(32'h3000_0010, 8'hC6);

        issue(1'b0, 23'h000C40, 32'h0, 4'h0, 4'd1, 4'd0);
        check_miss(4'b1000, 1'b0, 13'h000);
        fill_replay(4'b1000, 13'h003, 4'd1);
        check_read_hit(32'h4000_0010, 8'h1B);

        // Fifth tag: way0 is oldest and dirty from the earlier write.
        issue(1'b0, 23'h001040, 32'h0, 4'h0, 4'd1, 4'd0);
        check_miss(4'b0001, 1'b1, 13'h000);

        // Reset while the refill is pending; a late miss_done lands in INIT.
        WSHRST_N = 1'b0;
        cyc();
        chk("midmiss_rst_missreq", miss_req, 0);
        chk("midmiss_rst_ready", req_ready, 0);
        chk("midmiss_rst_taginit", taginit_en, 0);
        WSHRST_N  = 1'b1;
        miss_done = 1'b1;
        run_init();

        // miss_done while idle is ignored.
        miss_done = 1'b1;
        cyc();
        miss_done = 1'b0;
        chk("idle_done_wtag", rewrite_tag, 0);
        chk("idle_done_ready", req_ready, 1);
        cyc();
        chk("idle_done_ready2", req_ready, 1);

        // After re-init everything is invalid again: way0 victim, clean.
        issue(1'b0, 23'h001044, 32'h0, 4'h0, 4'd1, 4'd1);
        check_miss(4'b0001, 1'b0, 13'h000);
        fill_replay(4'b0001, 13'h004, 4'd1);
        check_read_hit(32'h1000_0011, 8'h6C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
